// File: rtl/msx_bus_pkg.sv
// Shared types and constants for the MSX bus master slice.
// Optional external wait support is enabled with MSXBUS_WAIT_EN.
package msx_bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_T1,
    ST_T2,
    ST_TW,
    ST_T3
  } bus_state_t;

  localparam logic CYCLE_MEM = 1'b0;
  localparam logic CYCLE_IO  = 1'b1;

  localparam int DEFAULT_IO_WAIT      = 1;
  localparam int DEFAULT_WAIT_TIMEOUT = 255;

  localparam logic [15:0] CH376_PORT = 16'h0010;

endpackage

// File: rtl/msx_wait_timer.sv
// 8-bit down counter shared by the fixed I/O waits and the external wait timeout.
module msx_wait_timer
  import msx_bus_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic       dec,
  input  logic [7:0] load_value,
  output logic       zero
);

  logic [7:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= 8'h00;
    end else if (load) begin
      count <= load_value;
    end else if (dec && (count != 8'h00)) begin
      count <= count - 8'h01;
    end
  end

  assign zero = (count == 8'h00);

endmodule

// File: rtl/msx_bus_master.sv
// MSX Z80-style bus master: turns command handshakes into T1/T2/TW/T3 bus cycles.
// Define MSXBUS_WAIT_EN to add the wait_n input with a timeout abort.
module msx_bus_master
  import msx_bus_pkg::*;
#(
  parameter int IO_WAIT      = DEFAULT_IO_WAIT,
  parameter int WAIT_TIMEOUT = DEFAULT_WAIT_TIMEOUT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_io,
  input  logic        cmd_write,
  input  logic [15:0] cmd_addr,
  input  logic [7:0]  cmd_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic        rsp_err,
  output logic [15:0] addr,
  output logic [7:0]  data_out,
  output logic        data_oe,
  input  logic [7:0]  data_in,
`ifdef MSXBUS_WAIT_EN
  input  logic        wait_n,
`endif
  output logic        iorq_n,
  output logic        mreq_n,
  output logic        rd_n,
  output logic        wr_n,
  output logic        sltsl_n
);

  localparam logic [7:0] FIXED_LOAD   = 8'(IO_WAIT - 1);
  localparam logic [7:0] TIMEOUT_LOAD = 8'(WAIT_TIMEOUT - 1);

  bus_state_t  state_q, state_d;
  logic        io_q, write_q;
  logic [15:0] addr_q;
  logic [7:0]  wdata_q;
  logic        rsp_valid_q;
  logic [7:0]  rsp_rdata_q;
  logic        timer_load, timer_dec, timer_zero, ext_entry;
  logic        strobe_on;

`ifdef MSXBUS_WAIT_EN
  logic ext_q, ext_d;
  logic abort;
  logic rsp_err_q;
`endif

  msx_wait_timer u_wait_timer (
    .clk        (clk),
    .reset      (reset),
    .load       (timer_load),
    .dec        (timer_dec),
    .load_value (ext_entry ? TIMEOUT_LOAD : FIXED_LOAD),
    .zero       (timer_zero)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
`ifdef MSXBUS_WAIT_EN
      ext_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
`ifdef MSXBUS_WAIT_EN
      ext_q   <= ext_d;
`endif
    end
  end

  // Fixed I/O waits are always served before any external wait is honoured.
  always_comb begin
    state_d    = state_q;
    timer_load = 1'b0;
    timer_dec  = 1'b0;
    ext_entry  = 1'b0;
`ifdef MSXBUS_WAIT_EN
    ext_d      = ext_q;
    abort      = 1'b0;
`endif
    case (state_q)
      ST_IDLE: if (cmd_valid) state_d = ST_T1;
      ST_T1:   state_d = ST_T2;
      ST_T2: begin
        if ((io_q == CYCLE_IO) && (IO_WAIT != 0)) begin
          state_d    = ST_TW;
          timer_load = 1'b1;
`ifdef MSXBUS_WAIT_EN
        end else if (!wait_n) begin
          state_d    = ST_TW;
          timer_load = 1'b1;
          ext_entry  = 1'b1;
          ext_d      = 1'b1;
`endif
        end else begin
          state_d = ST_T3;
        end
      end
      ST_TW: begin
`ifdef MSXBUS_WAIT_EN
        if (ext_q) begin
          if (wait_n) begin
            state_d = ST_T3;
            ext_d   = 1'b0;
          end else if (timer_zero) begin
            state_d = ST_IDLE;
            ext_d   = 1'b0;
            abort   = 1'b1;
          end else begin
            timer_dec = 1'b1;
          end
        end else if (!timer_zero) begin
          timer_dec = 1'b1;
        end else if (!wait_n) begin
          timer_load = 1'b1;
          ext_entry  = 1'b1;
          ext_d      = 1'b1;
        end else begin
          state_d = ST_T3;
        end
`else
        if (!timer_zero) timer_dec = 1'b1;
        else             state_d   = ST_T3;
`endif
      end
      ST_T3:   state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    strobe_on = (state_q == ST_T2) || (state_q == ST_TW) || (state_q == ST_T3);
    cmd_ready = (state_q == ST_IDLE);
    iorq_n    = !(strobe_on && (io_q == CYCLE_IO));
    mreq_n    = !(strobe_on && (io_q == CYCLE_MEM));
    sltsl_n   = !(strobe_on && (io_q == CYCLE_MEM));
    rd_n      = !(strobe_on && !write_q);
    wr_n      = !(strobe_on && write_q);
    data_oe   = write_q && (state_q != ST_IDLE);
    data_out  = wdata_q;
    addr      = addr_q;
    rsp_valid = rsp_valid_q;
    rsp_rdata = rsp_rdata_q;
  end

  // Command latch and response registers; the response pulses for one IDLE cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      io_q        <= CYCLE_MEM;
      write_q     <= 1'b0;
      addr_q      <= 16'h0000;
      wdata_q     <= 8'h00;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 8'h00;
`ifdef MSXBUS_WAIT_EN
      rsp_err_q   <= 1'b0;
`endif
    end else begin
      rsp_valid_q <= 1'b0;
`ifdef MSXBUS_WAIT_EN
      rsp_err_q   <= 1'b0;
`endif
      if ((state_q == ST_IDLE) && cmd_valid) begin
        io_q    <= cmd_io;
        write_q <= cmd_write;
        addr_q  <= cmd_addr;
        wdata_q <= cmd_wdata;
      end
      if (state_q == ST_T3) begin
        rsp_valid_q <= 1'b1;
        if (!write_q) rsp_rdata_q <= data_in;
      end
`ifdef MSXBUS_WAIT_EN
      if (abort) begin
        rsp_valid_q <= 1'b1;
        rsp_err_q   <= 1'b1;
      end
`endif
    end
  end

`ifdef MSXBUS_WAIT_EN
  assign rsp_err = rsp_err_q;
`else
  assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_msx_bus_master.sv
// Directed self-checking bench for msx_bus_master (extra wait tests under MSXBUS_WAIT_EN).
module tb_msx_bus_master;
  import msx_bus_pkg::*;

  localparam int IO_WAIT      = 1;
  localparam int WAIT_TIMEOUT = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid, cmd_ready, cmd_io, cmd_write;
  logic [15:0] cmd_addr;
  logic [7:0]  cmd_wdata;
  logic        rsp_valid, rsp_err;
  logic [7:0]  rsp_rdata;
  logic [15:0] addr;
  logic [7:0]  data_out, data_in;
  logic        data_oe;
  logic        iorq_n, mreq_n, rd_n, wr_n, sltsl_n;
`ifdef MSXBUS_WAIT_EN
  logic        wait_n;
`endif

  int test_count = 0;
  int fail_count = 0;
  int lat, io_cnt, mem_cnt, rd_cnt, wr_cnt, oe_cnt, viol;
  int pulses;

  msx_bus_master #(.IO_WAIT(IO_WAIT), .WAIT_TIMEOUT(WAIT_TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_io(cmd_io), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .addr(addr), .data_out(data_out), .data_oe(data_oe), .data_in(data_in),
`ifdef MSXBUS_WAIT_EN
    .wait_n(wait_n),
`endif
    .iorq_n(iorq_n), .mreq_n(mreq_n), .rd_n(rd_n), .wr_n(wr_n), .sltsl_n(sltsl_n)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    test_count++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Presents one command in IDLE and returns one cycle after the acceptance edge (T1).
  task automatic applyStimulus(input logic io, input logic write, input logic [15:0] a, input logic [7:0] wd);
    cmd_io    = io;
    cmd_write = write;
    cmd_addr  = a;
    cmd_wdata = wd;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
  endtask

  // Starting in T1, follows the cycle until rsp_valid, counting strobe activity.
  task automatic watchCycle(input string tag, input logic [15:0] exp_addr, input int wait_low_until,
                            output int n, output int ioc, output int memc, output int rdc,
                            output int wrc, output int oec, output int bad);
    n = 0; ioc = 0; memc = 0; rdc = 0; wrc = 0; oec = 0; bad = 0;
    checkOutput({tag, "_t1_strobes"}, {27'd0, iorq_n, mreq_n, rd_n, wr_n, sltsl_n}, 32'h1F);
    checkOutput({tag, "_t1_addr"}, {16'd0, addr}, {16'd0, exp_addr});
    checkOutput({tag, "_t1_ready"}, {31'd0, cmd_ready}, 32'd0);
    while (!rsp_valid && n < 40) begin
      if (!iorq_n) ioc++;
      if (!mreq_n && !sltsl_n) memc++;
      if (!rd_n) rdc++;
      if (!wr_n) wrc++;
      if (data_oe) oec++;
      if ((!rd_n && !wr_n) || (!iorq_n && !mreq_n)) bad++;
`ifdef MSXBUS_WAIT_EN
      wait_n = (n < wait_low_until) ? 1'b0 : 1'b1;
`else
      if (wait_low_until != 0) bad++;
`endif
      tick();
      n++;
    end
    checkOutput({tag, "_rsp_seen"}, {31'd0, rsp_valid}, 32'd1);
  endtask

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_io = 1'b0; cmd_write = 1'b0;
    cmd_addr = 16'h0; cmd_wdata = 8'h0; data_in = 8'h00;
`ifdef MSXBUS_WAIT_EN
    wait_n = 1'b1;
`endif
    tick(); tick();
    checkOutput("rst_strobes", {27'd0, iorq_n, mreq_n, rd_n, wr_n, sltsl_n}, 32'h1F);
    checkOutput("rst_misc", {28'd0, cmd_ready, data_oe, rsp_valid, rsp_err}, 32'b1000);
    checkOutput("rst_addr", {16'd0, addr}, 32'h0);
    checkOutput("rst_rdata", {24'd0, rsp_rdata}, 32'h0);
    reset = 1'b0;
    tick();

    // I/O read from the CH376 port
    data_in = 8'h5A;
    applyStimulus(CYCLE_IO, 1'b0, CH376_PORT, 8'h00);
    watchCycle("ioread", CH376_PORT, 0, lat, io_cnt, mem_cnt, rd_cnt, wr_cnt, oe_cnt, viol);
    checkOutput("ioread_lat", lat, 32'd4);
    checkOutput("ioread_iorq", io_cnt, 32'd3);
    checkOutput("ioread_rd", rd_cnt, 32'd3);
    checkOutput("ioread_mem", mem_cnt + wr_cnt + oe_cnt + viol, 32'd0);
    checkOutput("ioread_rdata", {24'd0, rsp_rdata}, 32'h5A);
    checkOutput("ioread_err_ready", {30'd0, rsp_err, cmd_ready}, 32'b01);
    checkOutput("ioread_idle_strobes", {27'd0, iorq_n, mreq_n, rd_n, wr_n, sltsl_n}, 32'h1F);
    tick();
    checkOutput("ioread_pulse_once", {31'd0, rsp_valid}, 32'd0);

    // Memory write
    data_in = 8'hEE;
    applyStimulus(CYCLE_MEM, 1'b1, 16'h5000, 8'h07);
    checkOutput("memwr_dout", {24'd0, data_out}, 32'h07);
    watchCycle("memwr", 16'h5000, 0, lat, io_cnt, mem_cnt, rd_cnt, wr_cnt, oe_cnt, viol);
    checkOutput("memwr_lat", lat, 32'd3);
    checkOutput("memwr_mem", mem_cnt, 32'd2);
    checkOutput("memwr_wr", wr_cnt, 32'd2);
    checkOutput("memwr_oe", oe_cnt, 32'd3);
    checkOutput("memwr_other", io_cnt + rd_cnt + viol, 32'd0);
    checkOutput("memwr_rdata_held", {24'd0, rsp_rdata}, 32'h5A);
    checkOutput("memwr_oe_off", {31'd0, data_oe}, 32'd0);
    tick();
    checkOutput("memwr_addr_hold", {16'd0, addr}, 32'h5000);

    // Back-to-back: memory read then I/O write accepted during the rsp_valid cycle
    data_in = 8'hC3;
    applyStimulus(CYCLE_MEM, 1'b0, 16'h7000, 8'h00);
    watchCycle("b2b_rd", 16'h7000, 0, lat, io_cnt, mem_cnt, rd_cnt, wr_cnt, oe_cnt, viol);
    checkOutput("b2b_rd_lat", lat, 32'd3);
    checkOutput("b2b_rd_rdata", {24'd0, rsp_rdata}, 32'hC3);
    checkOutput("b2b_rd_ready", {31'd0, cmd_ready}, 32'd1);
    applyStimulus(CYCLE_IO, 1'b1, 16'h0011, 8'h06);
    watchCycle("b2b_wr", 16'h0011, 0, lat, io_cnt, mem_cnt, rd_cnt, wr_cnt, oe_cnt, viol);
    checkOutput("b2b_wr_lat", lat, 32'd4);
    checkOutput("b2b_wr_iorq", io_cnt, 32'd3);
    checkOutput("b2b_wr_wr", wr_cnt, 32'd3);
    checkOutput("b2b_wr_oe", oe_cnt, 32'd4);
    checkOutput("b2b_wr_other", mem_cnt + rd_cnt + viol, 32'd0);
    checkOutput("b2b_wr_rdata_held", {24'd0, rsp_rdata}, 32'hC3);
    tick();

    // Reset asserted mid-T2 of an I/O read
    applyStimulus(CYCLE_IO, 1'b0, CH376_PORT, 8'h00);
    tick();
    checkOutput("rstmid_t2_iorq", {31'd0, iorq_n}, 32'd0);
    reset = 1'b1;
    #1;
    checkOutput("rstmid_strobes", {27'd0, iorq_n, mreq_n, rd_n, wr_n, sltsl_n}, 32'h1F);
    checkOutput("rstmid_oe_rsp", {30'd0, data_oe, rsp_valid}, 32'd0);
    tick();
    reset = 1'b0;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      if (rsp_valid) pulses++;
      tick();
    end
    checkOutput("rstmid_no_rsp", pulses, 32'd0);
    checkOutput("rstmid_ready", {31'd0, cmd_ready}, 32'd1);
    checkOutput("rstmid_addr", {16'd0, addr}, 32'h0);

`ifdef MSXBUS_WAIT_EN
    // External wait held low for three decision edges
    data_in = 8'h3C;
    applyStimulus(CYCLE_IO, 1'b0, CH376_PORT, 8'h00);
    watchCycle("wait3", CH376_PORT, 5, lat, io_cnt, mem_cnt, rd_cnt, wr_cnt, oe_cnt, viol);
    wait_n = 1'b1;
    checkOutput("wait3_lat", lat, 32'd7);
    checkOutput("wait3_iorq", io_cnt, 32'd6);
    checkOutput("wait3_rdata_err", {23'd0, rsp_err, rsp_rdata}, 32'h03C);
    tick();

    // wait_n stuck low: abort after WAIT_TIMEOUT external cycles
    data_in = 8'h99;
    applyStimulus(CYCLE_IO, 1'b0, CH376_PORT, 8'h00);
    watchCycle("tmo", CH376_PORT, 1000, lat, io_cnt, mem_cnt, rd_cnt, wr_cnt, oe_cnt, viol);
    checkOutput("tmo_lat", lat, 32'd11);
    checkOutput("tmo_err", {31'd0, rsp_err}, 32'd1);
    checkOutput("tmo_rdata_held", {24'd0, rsp_rdata}, 32'h3C);
    checkOutput("tmo_strobes", {27'd0, iorq_n, mreq_n, rd_n, wr_n, sltsl_n}, 32'h1F);
    wait_n = 1'b1;
    tick();
    checkOutput("tmo_pulse_once", {30'd0, rsp_valid, rsp_err}, 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
    $finish;
  end

endmodule

// File: doc/msx_bus_master.md
MSX_BUS_MASTER -- requirements
Module: msx_bus_master

Interface
REQ-001 Parameter IO_WAIT, default 1: number of fixed TW cycles inserted in every I/O cycle; memory cycles have none.
REQ-002 Parameter WAIT_TIMEOUT, default 255: maximum external wait cycles before abort; only used with MSXBUS_WAIT_EN.
REQ-003 One clock; reset is asynchronous and active-high.
REQ-004 clk  in  1  system clock; one bus T-state per clk cycle.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 cmd_valid / cmd_ready  in / out  1 / 1  command handshake; a command transfers when both are high on a rising edge.
REQ-007 cmd_io  in  1  1 selects an I/O cycle; 0 selects a memory cycle.
REQ-008 cmd_write  in  1  1 selects a write; 0 selects a read.
REQ-009 cmd_addr / cmd_wdata  in  16 / 8  bus address and write data.
REQ-010 rsp_valid  out  1  one-cycle pulse marking cycle completion.
REQ-011 rsp_rdata / rsp_err  out  8 / 1  read data; rsp_err flags a timeout abort.
REQ-012 addr  out  16  bus address.
REQ-013 data_out / data_oe / data_in  out / out / in  8 / 1 / 8  data bus drive, drive enable and sampled input.
REQ-014 iorq_n, mreq_n, rd_n, wr_n, sltsl_n  out  1 each  active-low bus strobes.
REQ-015 wait_n  in  1  active-low wait request; the port exists only with MSXBUS_WAIT_EN.

Function
REQ-016 FSM states: IDLE, T1, T2, TW, T3. cmd_ready is 1 only in IDLE.
REQ-017 Acceptance in IDLE: cmd_io, cmd_write, cmd_addr and cmd_wdata are latched and the FSM goes to T1.
REQ-018 T1: addr is driven with the latched address and all strobes are high.
REQ-019 T1, write: data_oe = 1 and data_out = latched data, held through T3.
REQ-020 T2 through T3: strobes are asserted.
  - I/O cycle: iorq_n = 0, mreq_n = 1, sltsl_n = 1.
  - Memory cycle: mreq_n = 0 and sltsl_n = 0.
  - Direction: rd_n = 0 for reads, wr_n = 0 for writes; rd_n and wr_n are never both 0.
REQ-021 After T2:
  - I/O cycles spend exactly IO_WAIT cycles in TW.
  - IO_WAIT = 0 goes directly to T3.
  - Memory cycles go T2 -> T3.
REQ-022 Read data: data_in is captured on the T3 -> IDLE edge into rsp_rdata, and rsp_valid pulses for the first IDLE cycle.
REQ-023 Write completion: rsp_valid pulses and rsp_rdata holds its previous value.
REQ-024 Latency from acceptance edge to rsp_valid: memory 3 cycles; I/O 3 + IO_WAIT cycles, plus external waits.
REQ-025 Leaving T3: strobes return high and data_oe returns to 0 in the same cycle.
REQ-026 addr holds its last value in IDLE.
REQ-027 Back-to-back: a new command may be accepted in the cycle rsp_valid is high; there is no idle gap beyond that cycle.
REQ-028 cmd_valid dropping outside IDLE has no effect; a started cycle always completes.

Reset
REQ-029 Reset values, asynchronous and applied immediately, including mid-cycle:
  - State = IDLE; cmd_ready = 1.
  - All strobes = 1; data_oe = 0.
  - addr = 0x0000; rsp_valid = 0; rsp_rdata = 0x00; rsp_err = 0.
REQ-030 A cycle interrupted by reset produces no rsp_valid.

Configuration
REQ-031 With MSXBUS_WAIT_EN defined:
  - In T2 or TW, a low wait_n sampled on the edge holds the FSM in TW, with strobes held, until wait_n is sampled high.
  - The hold then proceeds as if the fixed waits had ended; fixed waits are always served first.
REQ-032 With MSXBUS_WAIT_EN defined, timeout abort:
  - If external waits reach WAIT_TIMEOUT cycles, the FSM goes to IDLE with strobes high.
  - rsp_valid = 1 and rsp_err = 1 for one cycle; rsp_rdata is unchanged.
REQ-033 Without MSXBUS_WAIT_EN: wait_n is absent, rsp_err is tied to 0, and timing is fixed per REQ-024.

Structure
REQ-034 Package msx_bus_pkg holds:
  - the FSM state enum;
  - the I/O and memory cycle-type constants;
  - the default IO_WAIT and WAIT_TIMEOUT values;
  - the CH376 I/O port constant 0x10.
REQ-035 The wait/timeout counter (8-bit, load and decrement, zero flag) is the single sub-module, msx_wait_timer. The rest stays in msx_bus_master.

Verification
REQ-036 I/O read: port 0x0010, data_in = 0x5A, IO_WAIT = 1 -> iorq_n and rd_n low for 3 cycles, mreq_n and sltsl_n high, rsp_valid 4 cycles after acceptance, rsp_rdata = 0x5A.
REQ-037 Memory write: addr 0x5000, data 0x07 -> sltsl_n, mreq_n and wr_n low for 2 cycles, data_oe high for 3 cycles, rsp_valid 3 cycles after acceptance.
REQ-038 Back-to-back: memory read 0x7000 followed by I/O write 0x0011 data 0x06 -> second T1 immediately follows the first rsp_valid cycle, strobes never overlap.
REQ-039 Reset asserted during T2 of an I/O read -> strobes high and data_oe low within the same cycle, no rsp_valid, cmd_ready = 1 after release.
REQ-040 MSXBUS_WAIT_EN, wait_n low for 3 cycles on an I/O read -> rsp_valid delayed by exactly 3 cycles. wait_n held low -> abort after WAIT_TIMEOUT cycles with rsp_err = 1.
